// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder. Accepts one
//               read/write request at a time, waits a fixed LATENCY and
//               returns a one-cycle response with data or an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int          c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_DEPTH     = 32'(DEPTH_WORDS);
    // Wait-counter preload; unused when LATENCY=1 (no WAIT state then).
    localparam logic [2:0]  c_WAIT_LOAD = 3'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_op_we;
    logic [31:0] w_op_addr;
    logic [31:0] w_op_wdata;
    logic        w_op_err;
    logic [c_AW-1:0] w_op_idx;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_pend_rdata;
    logic        r_pend_err;

    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    assign w_accept     = (r_state == S_IDLE) && req_valid;
    assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);

    // With LATENCY=1 RESP is entered on the acceptance edge itself, before the
    // request registers hold it, so the live request is used in IDLE.
    assign w_op_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_op_idx   = w_op_addr[c_AW+1:2];
    // Full-width word-index compare so high address bits never alias.
    assign w_op_err   = (w_op_addr[1:0] != 2'b00) ||
                        ({2'b00, w_op_addr[31:2]} >= c_DEPTH);

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = c_WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Capture the request on acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Storage array: committed on the edge entering RESP unless reset wins.
    always_ff @(posedge clk) begin
        if (reset && w_enter_resp && w_op_we && !w_op_err) begin
            r_mem[w_op_idx] <= w_op_wdata;
        end
    end

    // Pending response captured on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend_rdata <= 32'd0;
            r_pend_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_pend_err   <= w_op_err;
            r_pend_rdata <= (w_op_we || w_op_err) ? 32'd0 : r_mem[w_op_idx];
        end
    end

    // Response outputs: strobe on leaving RESP, data/err held until the next one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else if (r_state == S_RESP) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_pend_rdata;
            r_resp_err   <= r_pend_err;
        end else begin
            r_resp_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
